phys_reg_free_list: RTL and testbench

// - Allocates physical registers to dispatch and reclaims them at commit, so each rename writes a unique phys_reg_file entry.
// - Sits between rename/dispatch (alloc side) and ROB commit (free side).
// - Circular FIFO of free physical register indices.
// - Keeps a committed-head copy for single-cycle recovery on flush.

---
 rtl/rv32i_types.sv | 17 +
 rtl/lane_prefix_count.sv | 32 +++
 rtl/phys_reg_free_list.sv | 116 +++++++++++
 tb/tb_phys_reg_free_list.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Package   : rv32i_types
//  Purpose   : Shared rename-stage types. The physical register index type is
//              used by the RAT, ROB and phys_reg_file request types.
//  Revision  : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Physical register file depth; the index width follows from it.
    localparam int TABLE_ENTRIES = 64;
    localparam int PREG_W        = $clog2(TABLE_ENTRIES);

    typedef logic [PREG_W-1:0] phys_reg_idx_t;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/lane_prefix_count.sv
`default_nettype none
// ============================================================================
//  Module    : lane_prefix_count
//  Purpose   : Turns a per-lane valid vector into exclusive prefix counts
//              (number of valid lanes strictly below each lane) plus the total.
//              Used to compact sparse lane requests onto consecutive slots.
//  Revision  : 1.0 - initial release
// ============================================================================
module lane_prefix_count #(
    parameter int SS = 2,
    parameter int CW = $clog2(SS + 1)
) (
    input  logic [SS-1:0]         valid_i,
    output logic [SS-1:0][CW-1:0] prefix_o,
    output logic [CW-1:0]         total_o
);

    logic [CW-1:0] run_count;

    // Running sum across lanes: each lane sees the count before adding itself.
    always_comb begin
        run_count = '0;
        prefix_o  = '0;
        for (int i = 0; i < SS; i++) begin
            prefix_o[i] = run_count;
            run_count   = run_count + CW'(valid_i[i]);
        end
        total_o = run_count;
    end

endmodule : lane_prefix_count
`default_nettype wire

// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
//  Module    : phys_reg_free_list
//  Purpose   : Circular FIFO of free physical register indices. Rename pops
//              up to SS entries per cycle (all-or-nothing), commit pushes up to
//              SS stale registers back. A committed-head pointer allows a
//              single-cycle rollback of speculative allocations on flush.
//  Revision  : 1.0 - initial release
// ============================================================================
module phys_reg_free_list
    import rv32i_types::*;
#(
    parameter int SS            = 2,
    parameter int TABLE_ENTRIES = 64,
    parameter int ARCH_REGS     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [SS-1:0]                alloc_req,
    output logic                         alloc_ready,
    output phys_reg_idx_t [SS-1:0]       alloc_preg,
    input  logic [SS-1:0]                free_valid,
    input  phys_reg_idx_t [SS-1:0]       free_preg,
    output logic [$clog2(TABLE_ENTRIES-ARCH_REGS+1)-1:0] free_count
);

    localparam int FE      = TABLE_ENTRIES - ARCH_REGS;  // must be a power of two
    localparam int PTR_W   = $clog2(FE);
    localparam int CNT_W   = $clog2(FE + 1);
    localparam int CNT_W1  = CNT_W + 1;                  // headroom for overflow check
    localparam int LANE_CW = $clog2(SS + 1);

    // Storage and pointers. Entries between retire_head and head are handed
    // out but not yet committed; flush returns them by rewinding head.
    phys_reg_idx_t     fifo_q [FE];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  retire_head_q, retire_head_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [SS-1:0][LANE_CW-1:0] alloc_prefix;
    logic [SS-1:0][LANE_CW-1:0] free_prefix;
    logic [LANE_CW-1:0]         n_req;
    logic [LANE_CW-1:0]         n_free;
    logic [CNT_W1-1:0]          count_sum;

    lane_prefix_count #(.SS(SS), .CW(LANE_CW)) u_alloc_prefix (
        .valid_i  (alloc_req),
        .prefix_o (alloc_prefix),
        .total_o  (n_req)
    );

    lane_prefix_count #(.SS(SS), .CW(LANE_CW)) u_free_prefix (
        .valid_i  (free_valid),
        .prefix_o (free_prefix),
        .total_o  (n_free)
    );

    // Grant decision, compacted read addressing and next-state pointers.
    always_comb begin
        alloc_ready = !flush && (CNT_W'(n_req) <= count_q);

        for (int i = 0; i < SS; i++) begin
            alloc_preg[i] = fifo_q[head_q + PTR_W'(alloc_prefix[i])];
        end

        // Wide sum so an illegal over-free is visible instead of wrapping.
        count_sum = CNT_W1'(count_q) + CNT_W1'(n_free)
                  - (alloc_ready ? CNT_W1'(n_req) : CNT_W1'(0));

        tail_d        = tail_q + PTR_W'(n_free);
        retire_head_d = retire_head_q + PTR_W'(n_free);
        head_d        = head_q;
        count_d       = count_sum[CNT_W-1:0];

        if (flush) begin
            // Nothing in flight after recovery: every allocation is matched.
            head_d  = retire_head_q + PTR_W'(n_free);
            count_d = CNT_W'(FE);
        end else if (alloc_ready) begin
            head_d  = head_q + PTR_W'(n_req);
        end
    end

    assign free_count = count_q;

    // FIFO writes for released registers plus pointer/count update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FE; i++) begin
                fifo_q[i] <= phys_reg_idx_t'(ARCH_REGS + i);
            end
            head_q        <= '0;
            tail_q        <= '0;
            retire_head_q <= '0;
            count_q       <= CNT_W'(FE);
        end else begin
            for (int i = 0; i < SS; i++) begin
                if (free_valid[i]) begin
                    fifo_q[tail_q + PTR_W'(free_prefix[i])] <= free_preg[i];
                end
            end
            head_q        <= head_d;
            tail_q        <= tail_d;
            retire_head_q <= retire_head_d;
            count_q       <= count_d;
        end
    end

    // Commit can never return more registers than the list can hold.
    a_no_overfree : assert property (@(posedge clk) disable iff (rst)
        !flush |-> (count_sum <= CNT_W1'(FE)));

endmodule : phys_reg_free_list
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`default_nettype none
// ============================================================================
//  Module    : tb_phys_reg_free_list
//  Purpose   : Self-checking bench for phys_reg_free_list. A queue model holds
//              the allocatable registers (in grant order) and the speculative
//              in-flight registers (oldest first); directed scenarios plus
//              random traffic are compared against it every cycle.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_phys_reg_free_list;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [1:0]      alloc_req;
    logic            alloc_ready;
    logic [1:0][5:0] alloc_preg;
    logic [1:0]      free_valid;
    logic [1:0][5:0] free_preg;
    logic [5:0]      free_count;

    always #5 clk = ~clk;

    phys_reg_free_list #(.SS(2), .TABLE_ENTRIES(64), .ARCH_REGS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_preg  (alloc_preg),
        .free_valid  (free_valid),
        .free_preg   (free_preg),
        .free_count  (free_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fq[$];   // allocatable registers, next grant at front
    int sq[$];   // granted but uncommitted registers, oldest at front

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pc(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        fq.delete();
        sq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(32 + i);
    endtask

    // Compare current outputs with the model, advance the model by this
    // cycle's inputs, then step to just after the next rising edge.
    task automatic tick();
        int  nreq;
        int  nfree;
        int  k;
        int  dummy;
        bit  rdy;
        #1;
        nreq = pc(alloc_req);
        rdy  = !flush && (nreq <= fq.size());
        if (!rst) begin
            chk("alloc_ready", int'(alloc_ready), int'(rdy));
            chk("free_count", int'(free_count), fq.size());
            if (rdy) begin
                k = 0;
                for (int l = 0; l < 2; l++) begin
                    if (alloc_req[l]) begin
                        chk($sformatf("alloc_preg[%0d]", l), int'(alloc_preg[l]), fq[k]);
                        k++;
                    end
                end
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            nfree = pc(free_valid);
            for (int j = 0; j < nfree; j++) dummy = sq.pop_front();
            if (flush) begin
                for (int j = sq.size() - 1; j >= 0; j--) fq.push_front(sq[j]);
                sq.delete();
            end else if (rdy) begin
                for (int l = 0; l < 2; l++)
                    if (alloc_req[l]) sq.push_back(fq.pop_front());
            end
            for (int l = 0; l < 2; l++)
                if (free_valid[l]) fq.push_back(int'(free_preg[l]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        alloc_req  = '0;
        free_valid = '0;
        free_preg  = '0;
        @(posedge clk);
        #1;
        tick();
        tick();

        // Scenario 1: post-reset outputs.
        rst = 1'b0;
        #1;
        chk("reset free_count", int'(free_count), 32);
        chk("reset alloc_ready", int'(alloc_ready), 1);
        chk("reset alloc_preg[0]", int'(alloc_preg[0]), 32);
        alloc_req = 2'b11;
        #1;
        chk("reset req11 alloc_preg[0]", int'(alloc_preg[0]), 32);
        chk("reset req11 alloc_preg[1]", int'(alloc_preg[1]), 33);

        // Scenario 2: drain the list with dual-lane grants.
        repeat (16) tick();
        #1;
        chk("drained free_count", int'(free_count), 0);
        chk("drained alloc_ready", int'(alloc_ready), 0);
        tick();
        #1;
        chk("stalled free_count", int'(free_count), 0);

        // Scenario 3: one free entry, only upper lane requests.
        alloc_req    = 2'b00;
        free_valid   = 2'b01;
        free_preg[0] = 6'd5;
        tick();
        free_valid = 2'b00;
        alloc_req  = 2'b10;
        #1;
        chk("single free_count", int'(free_count), 1);
        chk("single alloc_ready", int'(alloc_ready), 1);
        chk("single alloc_preg[1]", int'(alloc_preg[1]), 5);
        tick();
        #1;
        chk("single after free_count", int'(free_count), 0);

        // Scenario 4: simultaneous alloc and free at count 2.
        alloc_req    = 2'b00;
        free_valid   = 2'b11;
        free_preg[0] = 6'd9;
        free_preg[1] = 6'd11;
        tick();
        alloc_req    = 2'b11;
        free_preg[0] = 6'd5;
        free_preg[1] = 6'd7;
        #1;
        chk("simul alloc_ready", int'(alloc_ready), 1);
        chk("simul alloc_preg[0]", int'(alloc_preg[0]), 9);
        chk("simul alloc_preg[1]", int'(alloc_preg[1]), 11);
        tick();
        free_valid = 2'b00;
        #1;
        chk("simul free_count", int'(free_count), 2);
        chk("simul next alloc_preg[0]", int'(alloc_preg[0]), 5);
        chk("simul next alloc_preg[1]", int'(alloc_preg[1]), 7);
        tick();

        // Scenario 5: flush after 6 allocations and 2 commits.
        rst       = 1'b1;
        alloc_req = 2'b00;
        tick();
        rst       = 1'b0;
        alloc_req = 2'b11;
        repeat (3) tick();
        alloc_req    = 2'b00;
        free_valid   = 2'b11;
        free_preg[0] = 6'd40;
        free_preg[1] = 6'd41;
        tick();
        free_valid = 2'b00;
        flush      = 1'b1;
        alloc_req  = 2'b11;
        #1;
        chk("flush cycle alloc_ready", int'(alloc_ready), 0);
        tick();
        flush     = 1'b0;
        alloc_req = 2'b01;
        #1;
        chk("post-flush free_count", int'(free_count), 32);
        chk("post-flush alloc_preg[0]", int'(alloc_preg[0]), 34);
        tick();

        // Scenario 6: reset while busy at count 10.
        rst       = 1'b1;
        alloc_req = 2'b00;
        tick();
        rst       = 1'b0;
        alloc_req = 2'b11;
        repeat (11) tick();
        alloc_req = 2'b00;
        #1;
        chk("busy free_count", int'(free_count), 10);
        rst          = 1'b1;
        alloc_req    = 2'b11;
        free_valid   = 2'b11;
        free_preg[0] = 6'd3;
        free_preg[1] = 6'd4;
        tick();
        rst        = 1'b0;
        alloc_req  = 2'b00;
        free_valid = 2'b00;
        #1;
        chk("mid-rst free_count", int'(free_count), 32);
        chk("mid-rst alloc_ready", int'(alloc_ready), 1);
        chk("mid-rst alloc_preg[0]", int'(alloc_preg[0]), 32);
        alloc_req = 2'b11;
        #1;
        chk("mid-rst req11 alloc_preg[0]", int'(alloc_preg[0]), 32);
        chk("mid-rst req11 alloc_preg[1]", int'(alloc_preg[1]), 33);
        tick();

        // Random traffic: first phase frees sparsely to reach the empty boundary.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] fv;
            rst       = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            alloc_req = 2'($urandom);
            if (cyc < 1500) fv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            else            fv = 2'($urandom);
            if (pc(fv) > sq.size()) fv = (sq.size() == 0) ? 2'b00 : 2'b01;
            free_valid   = fv;
            free_preg[0] = 6'($urandom_range(0, 63));
            free_preg[1] = 6'($urandom_range(0, 63));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_phys_reg_free_list
`default_nettype wire
